fetch_buffer: RTL



---
 rtl/cpu_defs.sv | 17 +
 rtl/fetch_addr_check.sv | 23 ++
 rtl/fetch_buffer.sv | 107 ++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: reset PC, exception codes and the fetch-buffer entry layout.
package cpu_defs;

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Exception codes, shared with the CP0 logic.
  localparam logic [4:0]  EXC_NONE  = 5'd0;
  localparam logic [4:0]  EXC_ADEL  = 5'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
  } fb_entry_t;

endpackage

// File: rtl/fetch_addr_check.sv
// Fetch address checker: flags misaligned or out-of-window fetch PCs as AdEL.
module fetch_addr_check
  import cpu_defs::*;
#(
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_BYTES = 4096
) (
  input  logic [31:0] pc,
  output logic        bad,
  output logic [4:0]  exc
);

  // The window end is kept 33 bits wide so a window touching the top of the
  // address space does not wrap to zero.
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + 33'(IM_BYTES);

  // Alignment and window check, all unsigned.
  always_comb begin
    bad = (pc[1:0] != 2'b00) | (pc < IM_BASE) | ({1'b0, pc} >= IM_END);
    exc = bad ? EXC_ADEL : EXC_NONE;
  end

endmodule

// File: rtl/fetch_buffer.sv
// Fetch buffer: small in-order queue of {pc, instr, exc} between fetch and decode.
// in_ready back-pressures the PC register; flush empties the queue in one edge.
module fetch_buffer
  import cpu_defs::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] PC_RESET = cpu_defs::PC_RESET,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_BYTES = 4096,
  localparam int         AW       = $clog2(DEPTH),
  localparam int         CW       = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_instr,
  output logic          in_ready,
  input  logic          flush,
  output logic          out_valid,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_instr,
  output logic [4:0]    out_exc,
  input  logic          out_ready,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  fb_entry_t     mem_q [DEPTH];
  fb_entry_t     entry_d;
  fb_entry_t     head;
  logic          push, pop;
  logic          addr_bad;
  logic [4:0]    addr_exc;

  fetch_addr_check #(
    .IM_BASE  (IM_BASE),
    .IM_BYTES (IM_BYTES)
  ) u_addr_check (
    .pc  (in_pc),
    .bad (addr_bad),
    .exc (addr_exc)
  );

  // Handshakes and entry formation; a bad address is stored as a nop carrying AdEL.
  always_comb begin
    in_ready      = (cnt_q < DEPTH_C);
    out_valid     = (cnt_q != '0);
    push          = in_valid & in_ready & ~flush;
    pop           = out_valid & out_ready & ~flush;
    entry_d.pc    = in_pc;
    entry_d.instr = addr_bad ? NOP_INSTR : in_instr;
    entry_d.exc   = addr_exc;
  end

  // Next-state for pointers and occupancy; flush overrides everything.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = AW'(wr_ptr_q + 1'b1);
      if (pop)  rd_ptr_d = AW'(rd_ptr_q + 1'b1);
      case ({push, pop})
        2'b10:   cnt_d = CW'(cnt_q + 1'b1);
        2'b01:   cnt_d = CW'(cnt_q - 1'b1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry_d;
  end

  // Head presentation: reset values whenever the queue is empty.
  always_comb begin
    head      = mem_q[rd_ptr_q];
    out_pc    = out_valid ? head.pc    : PC_RESET;
    out_instr = out_valid ? head.instr : NOP_INSTR;
    out_exc   = out_valid ? head.exc   : EXC_NONE;
    count     = cnt_q;
  end

endmodule
